mc_ctrl_fsm: RTL

- Multi-cycle MIPS control unit: Moore FSM plus an ALUOp decoder.
- Sits directly upstream of the ALU and drives its ALUOp, operand selects and all datapath write enables.
- Consumes IR opcode/funct and the ALU Zero flag.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps of 3–5 cycles.

---
 rtl/mc_ctrl_fsm_pkg.sv | 105 ++++++++++
 rtl/mc_ctrl_fsm_alu_dec.sv | 79 +++++++
 rtl/mc_ctrl_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, ALU codes,
// datapath select constants and the Op/Funct values the decoder recognises.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  // Which ALU decode the current state asks for
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_SUB   = 3'd2,
    CLS_RTYPE = 3'd3,
    CLS_RCHK  = 3'd4,
    CLS_ITYPE = 3'd5
  } alu_cls_e;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [1:0] NPC_ALU    = 2'd0;
  localparam logic [1:0] NPC_ALUOUT = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REGA   = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REGA  = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;
  localparam logic [1:0] SRCA_C16   = 2'd3;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic is_itype_op(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// Combinational ALUOp decoder: {state class, Op, Funct} -> ALUOp, an optional
// operand-A override for shifts/lui, and a valid flag for unknown encodings.
module mc_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [2:0] cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       srca_ovr,
  output logic [1:0] srca_sel,
  output logic       valid
);

  logic [3:0] r_alu;
  logic       r_shamt;
  logic       r_valid;

  always_comb begin
    r_alu   = ALU_NOP;
    r_shamt = 1'b0;
    r_valid = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: r_alu = ALU_ADD;
      FN_SUB, FN_SUBU: r_alu = ALU_SUB;
      FN_AND:          r_alu = ALU_AND;
      FN_OR:           r_alu = ALU_OR;
      FN_XOR:          r_alu = ALU_XOR;
      FN_NOR:          r_alu = ALU_NOR;
      FN_SLT:          r_alu = ALU_SLT;
      FN_SLTU:         r_alu = ALU_SLTU;
      FN_SLL: begin r_alu = ALU_SLL; r_shamt = 1'b1; end
      FN_SRL: begin r_alu = ALU_SRL; r_shamt = 1'b1; end
      FN_SRA: begin r_alu = ALU_SRA; r_shamt = 1'b1; end
      FN_SLLV:         r_alu = ALU_SLL;
      FN_SRLV:         r_alu = ALU_SRL;
      FN_SRAV:         r_alu = ALU_SRA;
      FN_JR, FN_JALR:  r_alu = ALU_NOP;
      default:         r_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_op   = ALU_NOP;
    srca_ovr = 1'b0;
    srca_sel = SRCA_PC;
    valid    = 1'b1;
    case (alu_cls_e'(cls))
      CLS_ADD: alu_op = ALU_ADD;
      CLS_SUB: alu_op = ALU_SUB;
      CLS_RTYPE: begin
        alu_op   = r_alu;
        srca_ovr = r_shamt;
        srca_sel = SRCA_SHAMT;
        valid    = r_valid;
      end
      // Writeback only needs to know whether the funct was legal
      CLS_RCHK: valid = r_valid;
      CLS_ITYPE: begin
        case (op)
          OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
          OP_SLTI:           alu_op = ALU_SLT;
          OP_SLTIU:          alu_op = ALU_SLTU;
          OP_ANDI:           alu_op = ALU_AND;
          OP_ORI:            alu_op = ALU_OR;
          OP_XORI:           alu_op = ALU_XOR;
          OP_LUI: begin
            alu_op   = ALU_SLL;
            srca_ovr = 1'b1;
            srca_sel = SRCA_C16;
          end
          default: valid = 1'b0;
        endcase
      end
      default: alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: state register plus Moore output decode
// (PCWrite in S_BRANCH follows Zero). All outputs are forced idle while rst is high.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [1:0] NPCOp,
  output logic [3:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic [3:0] dec_alu_op;
  logic       dec_srca_ovr;
  logic [1:0] dec_srca_sel;
  logic       dec_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    alu_cls = CLS_NONE;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR: alu_cls = CLS_ADD;
      S_BRANCH:                    alu_cls = CLS_SUB;
      S_EXE:                       alu_cls = CLS_RTYPE;
      S_ALUWB:                     alu_cls = CLS_RCHK;
      S_IEXE:                      alu_cls = CLS_ITYPE;
      default:                     alu_cls = CLS_NONE;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls      (alu_cls),
    .op       (Op),
    .funct    (Funct),
    .alu_op   (dec_alu_op),
    .srca_ovr (dec_srca_ovr),
    .srca_sel (dec_srca_sel),
    .valid    (dec_valid)
  );

  always_comb begin
    state_d  = S_FETCH;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = RD_RT;
    WDSel    = WD_ALUOUT;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_REGB;
    EXTOp    = 1'b0;
    NPCOp    = NPC_ALU;
    ALUOp    = dec_alu_op;
    Illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so S_BRANCH can load it from ALUOut
        ALUSrcB = SRCB_IMM2;
        EXTOp   = 1'b1;
        case (Op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = (Funct == FN_JR || Funct == FN_JALR) ? S_JUMP : S_EXE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          default: begin
            if (is_itype_op(Op)) begin
              state_d = S_IEXE;
            end else begin
              state_d = S_FETCH;
              Illegal = STRICT_DECODE;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        EXTOp   = 1'b1;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        RegDst   = RD_RT;
        WDSel    = WD_MDR;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXE: begin
        ALUSrcA = dec_srca_ovr ? dec_srca_sel : SRCA_REGA;
        ALUSrcB = SRCB_REGB;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        // An unknown funct travels through S_EXE as a NOP and is dropped here
        RegWrite = dec_valid;
        RegDst   = RD_RD;
        WDSel    = WD_ALUOUT;
        Illegal  = !dec_valid && STRICT_DECODE;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_REGB;
        NPCOp   = NPC_ALUOUT;
        PCWrite = (Op == OP_BNE) ? !Zero : Zero;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        if (Op == OP_RTYPE) begin
          NPCOp = NPC_REGA;
          if (Funct == FN_JALR) begin
            RegWrite = 1'b1;
            RegDst   = RD_RD;
            WDSel    = WD_PC;
          end
        end else begin
          NPCOp = NPC_JUMP;
          if (Op == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = RD_RA;
            WDSel    = WD_PC;
          end
        end
      end
      S_IEXE: begin
        ALUSrcA = dec_srca_ovr ? dec_srca_sel : SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        EXTOp   = (Op == OP_ADDI || Op == OP_ADDIU || Op == OP_SLTI || Op == OP_SLTIU);
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        RegDst   = RD_RT;
        WDSel    = WD_ALUOUT;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      state_d  = S_FETCH;
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = RD_RT;
      WDSel    = WD_ALUOUT;
      ALUSrcA  = SRCA_PC;
      ALUSrcB  = SRCB_REGB;
      EXTOp    = 1'b0;
      NPCOp    = NPC_ALU;
      ALUOp    = ALU_NOP;
      Illegal  = 1'b0;
    end
  end

  assign State = state_q;

endmodule
